// File: rtl/lifo_arb_pkg.sv
// Shared types and helpers for the LIFO arbiter: operation encoding and
// rotating-priority index arithmetic.
package lifo_arb_pkg;

  typedef enum logic {
    OP_POP  = 1'b0,
    OP_PUSH = 1'b1
  } op_t;

  // Client index reached after stepping ofs places from base, wrapping at n.
  function automatic int unsigned rr_idx(input int unsigned base,
                                         input int unsigned ofs,
                                         input int unsigned n);
    return (base + ofs) % n;
  endfunction

endpackage

// File: rtl/lifo_arb_rr_arbiter.sv
// Combinational round-robin picker: first eligible client scanning upward
// from i_ptr with wrap-around.
module rr_arbiter
  import lifo_arb_pkg::*;
#(
  parameter  int NUM_CLIENTS = 4,
  localparam int CWIDTH      = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] i_elig,
  input  logic [CWIDTH-1:0]      i_ptr,
  output logic [NUM_CLIENTS-1:0] o_grant,
  output logic [CWIDTH-1:0]      o_idx,
  output logic                   o_valid
);

  logic [CWIDTH-1:0] w_cand [NUM_CLIENTS];

  for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_cand
    assign w_cand[k] = CWIDTH'(rr_idx(32'(i_ptr), 32'(k), NUM_CLIENTS));
  end

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (!o_valid && i_elig[w_cand[k]]) begin
        o_valid             = 1'b1;
        o_idx               = w_cand[k];
        o_grant[w_cand[k]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lifo_arb.sv
// Shares one LIFO between NUM_CLIENTS push/pop requesters with a round-robin
// scheduler, returns pop data tagged by client, and sequences LIFO reset/flush.
module lifo_arb
  import lifo_arb_pkg::*;
#(
  parameter  int NUM_CLIENTS = 4,
  parameter  int DWIDTH      = 8,
  parameter  int AWIDTH      = 4,
  localparam int CWIDTH      = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic [NUM_CLIENTS-1:0]        req_valid_i,
  input  logic [NUM_CLIENTS-1:0]        req_push_i,
  input  logic [NUM_CLIENTS*DWIDTH-1:0] req_data_i,
  output logic [NUM_CLIENTS-1:0]        req_ready_o,
  output logic                          rd_valid_o,
  output logic [CWIDTH-1:0]             rd_client_o,
  output logic [DWIDTH-1:0]             rd_data_o,
  output logic                          lifo_srst_o,
  output logic                          lifo_wrreq_o,
  output logic [DWIDTH-1:0]             lifo_data_o,
  output logic                          lifo_rdreq_o,
  input  logic [DWIDTH-1:0]             lifo_q_i,
  input  logic                          lifo_empty_i,
  input  logic                          lifo_full_i,
  input  logic [AWIDTH:0]               lifo_usedw_i
);

  logic [CWIDTH-1:0]      r_ptr;
  logic [CWIDTH-1:0]      r_rd_client;
  logic                   r_rd_valid;
  logic                   r_srst;

  logic [NUM_CLIENTS-1:0] w_elig;
  logic [NUM_CLIENTS-1:0] w_grant;
  logic [CWIDTH-1:0]      w_gidx;
  logic                   w_gvalid;
  logic                   w_block;
  logic [CWIDTH-1:0]      w_ptr_nxt;
  op_t                    w_op;

  // Nothing is granted while the LIFO is being reset or a flush is requested.
  assign w_block = r_srst | flush_i;

  always_comb begin
    w_elig = '0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      w_elig[c] = req_valid_i[c] && !w_block &&
                  (req_push_i[c] ? !lifo_full_i : !lifo_empty_i);
    end
  end

  rr_arbiter #(
    .NUM_CLIENTS(NUM_CLIENTS)
  ) u_rr (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_gidx),
    .o_valid(w_gvalid)
  );

  assign w_op         = op_t'(req_push_i[w_gidx]);
  assign w_ptr_nxt    = CWIDTH'(rr_idx(32'(w_gidx), 32'd1, NUM_CLIENTS));

  assign req_ready_o  = w_grant;
  assign lifo_wrreq_o = w_gvalid && (w_op == OP_PUSH);
  assign lifo_rdreq_o = w_gvalid && (w_op == OP_POP);
  assign lifo_data_o  = lifo_wrreq_o ? req_data_i[w_gidx*DWIDTH +: DWIDTH] : '0;

  assign lifo_srst_o  = r_srst;
  assign rd_valid_o   = r_rd_valid;
  assign rd_client_o  = r_rd_client;
  // LIFO q_o already lags rdreq by one cycle, aligned with r_rd_valid.
  assign rd_data_o    = lifo_q_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_srst      <= 1'b1;
      r_ptr       <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_client <= '0;
    end else begin
      r_srst     <= flush_i;
      r_rd_valid <= lifo_rdreq_o;
      if (w_gvalid) begin
        r_ptr <= w_ptr_nxt;
      end
      if (lifo_rdreq_o) begin
        r_rd_client <= w_gidx;
      end
    end
  end

`ifndef SYNTHESIS
  localparam logic [AWIDTH:0] LP_DEPTH = {1'b1, {AWIDTH{1'b0}}};

  a_usedw_full: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (lifo_usedw_i == LP_DEPTH) |-> lifo_full_i);

  a_usedw_empty: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (lifo_usedw_i == '0) |-> lifo_empty_i);
`endif

endmodule

// File: tb/tb_lifo_arb.sv
// Directed bench for lifo_arb with a behavioural LIFO attached and a
// scoreboard of expected pop returns.
module tb_lifo_arb;

  localparam int NC    = 4;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int CW    = 2;
  localparam int DEPTH = 16;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 flush = 1'b0;
  logic [NC-1:0]        req_valid = '0;
  logic [NC-1:0]        req_push  = '0;
  logic [NC*DW-1:0]     req_data  = '0;
  logic [NC-1:0]        req_ready;
  logic                 rd_valid;
  logic [CW-1:0]        rd_client;
  logic [DW-1:0]        rd_data;
  logic                 lifo_srst;
  logic                 lifo_wrreq;
  logic [DW-1:0]        lifo_data;
  logic                 lifo_rdreq;

  // Behavioural LIFO: sync reset, flags from registered count, 1-cycle q.
  logic [DW-1:0]        mem [DEPTH];
  logic [AW:0]          usedw = '0;
  logic [DW-1:0]        lq    = '0;
  logic                 l_empty;
  logic                 l_full;

  assign l_empty = (usedw == (AW+1)'(0));
  assign l_full  = (usedw == (AW+1)'(DEPTH));

  always @(posedge clk) begin
    if (lifo_srst) begin
      usedw <= '0;
      lq    <= '0;
    end else if (lifo_wrreq && !l_full) begin
      mem[usedw[AW-1:0]] <= lifo_data;
      usedw <= usedw + 1'b1;
    end else if (lifo_rdreq && !l_empty) begin
      lq    <= mem[AW'(usedw - 1'b1)];
      usedw <= usedw - 1'b1;
    end
  end

  lifo_arb #(
    .NUM_CLIENTS(NC),
    .DWIDTH     (DW),
    .AWIDTH     (AW)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_push_i  (req_push),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .rd_valid_o  (rd_valid),
    .rd_client_o (rd_client),
    .rd_data_o   (rd_data),
    .lifo_srst_o (lifo_srst),
    .lifo_wrreq_o(lifo_wrreq),
    .lifo_data_o (lifo_data),
    .lifo_rdreq_o(lifo_rdreq),
    .lifo_q_i    (lq),
    .lifo_empty_i(l_empty),
    .lifo_full_i (l_full),
    .lifo_usedw_i(usedw)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]    stk [$];
  logic [CW+DW-1:0] sb  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [NC-1:0] rdy,
                           input logic wr, input logic rd, input logic [DW-1:0] d);
    chk({tag, ".ready"}, 32'(req_ready),  32'(rdy));
    chk({tag, ".wrreq"}, 32'(lifo_wrreq), 32'(wr));
    chk({tag, ".rdreq"}, 32'(lifo_rdreq), 32'(rd));
    chk({tag, ".data"},  32'(lifo_data),  32'(d));
  endtask

  task automatic set_cli(input int c, input logic v, input logic p, input logic [DW-1:0] d);
    req_valid[c]         = v;
    req_push[c]          = p;
    req_data[c*DW +: DW] = d;
  endtask

  task automatic exp_pop(input int c);
    logic [DW-1:0] d;
    d = stk.pop_back();
    sb.push_back({CW'(c), d});
  endtask

  // Pop-return monitor
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rd_spurious", 32'(rd_valid), 32'd0);
      end else begin
        logic [CW+DW-1:0] e;
        e = sb.pop_front();
        chk("rd_client", 32'(rd_client), 32'(e[CW+DW-1:DW]));
        chk("rd_data",   32'(rd_data),   32'(e[DW-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC-1:0] rr_exp;

    #2 rst_n = 1'b0;
    for (int c = 0; c < NC; c++) set_cli(c, 1'b1, 1'b1, 8'hC0 + 8'(c));

    // Reset held: srst asserted, nothing granted
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst.srst",   32'(lifo_srst), 32'd1);
      chk("rst.rdv",    32'(rd_valid),  32'd0);
      chk("rst.client", 32'(rd_client), 32'd0);
      chk_grant("rst", '0, 1'b0, 1'b0, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.srst", 32'(lifo_srst), 32'd1);
    chk_grant("rel", '0, 1'b0, 1'b0, '0);

    // Round-robin pushes until full
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); #1;
      if (i == 0) begin
        chk("rr.srst0",  32'(lifo_srst), 32'd0);
        chk("rr.usedw0", 32'(usedw),     32'd0);
      end
      rr_exp = NC'(1) << (i % NC);
      chk_grant("rr", rr_exp, 1'b1, 1'b0, 8'hC0 + 8'(i % NC));
      stk.push_back(8'hC0 + 8'(i % NC));
    end
    @(negedge clk); #1;
    chk("full.flag",  32'(l_full), 32'd1);
    chk("full.usedw", 32'(usedw),  32'd16);
    chk_grant("full", '0, 1'b0, 1'b0, '0);

    // Full: blocked pusher skipped, popper served
    set_cli(0, 1'b1, 1'b1, 8'h77);
    set_cli(1, 1'b0, 1'b0, 8'h00);
    set_cli(2, 1'b1, 1'b0, 8'h00);
    set_cli(3, 1'b0, 1'b0, 8'h00);
    #1;
    chk_grant("fs_pop", 4'b0100, 1'b0, 1'b1, '0);
    exp_pop(2);
    @(negedge clk); #1;
    chk_grant("fs_push", 4'b0001, 1'b1, 1'b0, 8'h77);
    stk.push_back(8'h77);
    @(negedge clk);
    set_cli(0, 1'b0, 1'b0, 8'h00);
    #1;
    chk_grant("fs_pop2", 4'b0100, 1'b0, 1'b1, '0);
    exp_pop(2);
    repeat (6) begin
      @(negedge clk); #1;
      chk_grant("drain", 4'b0100, 1'b0, 1'b1, '0);
      exp_pop(2);
    end

    // Flush with a pop in flight
    @(negedge clk);
    set_cli(2, 1'b0, 1'b0, 8'h00);
    set_cli(1, 1'b1, 1'b0, 8'h00);
    #1;
    chk("fl.usedw9", 32'(usedw), 32'd9);
    chk_grant("fl_pop", 4'b0010, 1'b0, 1'b1, '0);
    exp_pop(1);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl.srst_pre", 32'(lifo_srst), 32'd0);
    chk("fl.rdv",      32'(rd_valid),  32'd1);
    chk_grant("fl_req", '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl.srst", 32'(lifo_srst), 32'd1);
    chk("fl.rdv0", 32'(rd_valid),  32'd0);
    chk_grant("fl_srst", '0, 1'b0, 1'b0, '0);
    stk.delete();
    @(negedge clk); #1;
    chk("fl.srst_post", 32'(lifo_srst), 32'd0);
    chk("fl.usedw0",    32'(usedw),     32'd0);
    chk("fl.empty",     32'(l_empty),   32'd1);
    chk_grant("fl_empty", '0, 1'b0, 1'b0, '0);

    // LIFO order: client1 pushes three words, client3 pops them back
    set_cli(1, 1'b1, 1'b1, 8'hA1);
    #1;
    chk_grant("ord_p0", 4'b0010, 1'b1, 1'b0, 8'hA1);
    stk.push_back(8'hA1);
    @(negedge clk);
    set_cli(1, 1'b1, 1'b1, 8'hB2);
    #1;
    chk_grant("ord_p1", 4'b0010, 1'b1, 1'b0, 8'hB2);
    stk.push_back(8'hB2);
    @(negedge clk);
    set_cli(1, 1'b1, 1'b1, 8'hC3);
    #1;
    chk_grant("ord_p2", 4'b0010, 1'b1, 1'b0, 8'hC3);
    stk.push_back(8'hC3);
    @(negedge clk);
    set_cli(1, 1'b0, 1'b0, 8'h00);
    set_cli(3, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk_grant("ord_pop", 4'b1000, 1'b0, 1'b1, '0);
      exp_pop(3);
    end
    @(negedge clk);
    set_cli(3, 1'b0, 1'b0, 8'h00);
    #1;
    chk("ord.rdv_last", 32'(rd_valid), 32'd1);
    chk("ord.empty",    32'(l_empty),  32'd1);
    @(negedge clk); #1;
    chk("ord.rdv_idle", 32'(rd_valid), 32'd0);

    // Empty boundary: only the pusher can go, then one pop, then blocked
    set_cli(0, 1'b1, 1'b1, 8'h5A);
    for (int c = 1; c < NC; c++) set_cli(c, 1'b1, 1'b0, 8'h00);
    #1;
    chk_grant("emp_push", 4'b0001, 1'b1, 1'b0, 8'h5A);
    stk.push_back(8'h5A);
    @(negedge clk);
    set_cli(0, 1'b0, 1'b0, 8'h00);
    #1;
    chk_grant("emp_pop", 4'b0010, 1'b0, 1'b1, '0);
    exp_pop(1);
    @(negedge clk); #1;
    chk("emp.rdv", 32'(rd_valid), 32'd1);
    chk_grant("emp_blk", '0, 1'b0, 1'b0, '0);
    @(negedge clk); #1;
    chk_grant("emp_blk2", '0, 1'b0, 1'b0, '0);

    // Asynchronous reset while a pop return is pending
    set_cli(1, 1'b0, 1'b0, 8'h00);
    set_cli(3, 1'b0, 1'b0, 8'h00);
    set_cli(2, 1'b1, 1'b1, 8'h33);
    #1;
    chk_grant("ar_push", 4'b0100, 1'b1, 1'b0, 8'h33);
    @(negedge clk);
    set_cli(2, 1'b1, 1'b0, 8'h00);
    #1;
    chk_grant("ar_pop", 4'b0100, 1'b0, 1'b1, '0);
    @(posedge clk); #2;
    chk("ar.rdv_pre",    32'(rd_valid),  32'd1);
    chk("ar.client_pre", 32'(rd_client), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("ar.rdv",    32'(rd_valid),  32'd0);
    chk("ar.client", 32'(rd_client), 32'd0);
    chk("ar.srst",   32'(lifo_srst), 32'd1);
    chk("ar.ready",  32'(req_ready), 32'd0);
    stk.delete();
    set_cli(2, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar.srst_hold", 32'(lifo_srst), 32'd1);
    @(negedge clk); #1;
    chk("ar.srst_rel", 32'(lifo_srst), 32'd0);
    chk("ar.usedw",    32'(usedw),     32'd0);

    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
